// File: rtl/uart_dbg_master_if.sv
// Device-bus interface for the UART debug master.
//   master modport: bus initiator (drives request, enable, address, data, byte select)
//   slave modport : arbiter/responder side (drives grant, busy, load data)
// Signal names keep the device-bus naming used across the rest of the system.
`timescale 1ns/1ps
interface uart_dbg_master_if;
  logic        busReq_o;
  logic        busGnt_i;
  logic        devEnable_o;
  logic        devWrite_o;
  logic [31:0] devPhysicalAddr_o;
  logic [31:0] devDataSave_o;
  logic [3:0]  devByteSelect_o;
  logic        devBusy_i;
  logic [31:0] devDataLoad_i;

  modport master (
    output busReq_o,
    output devEnable_o,
    output devWrite_o,
    output devPhysicalAddr_o,
    output devDataSave_o,
    output devByteSelect_o,
    input  busGnt_i,
    input  devBusy_i,
    input  devDataLoad_i
  );

  modport slave (
    input  busReq_o,
    input  devEnable_o,
    input  devWrite_o,
    input  devPhysicalAddr_o,
    input  devDataSave_o,
    input  devByteSelect_o,
    output busGnt_i,
    output devBusy_i,
    output devDataLoad_i
  );
endinterface

// File: rtl/uart_dbg_master.sv
// UART debug master: turns byte commands received over a UART into single device-bus
// accesses and sends the result back over the UART.
//   'R' a0 a1 a2 a3             -> read, reply d0 d1 d2 d3 (little-endian) or 'E'
//   'W' a0..a3 d0..d3 be        -> write, reply 'K' or 'E'
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rxdReady_i, rxdData_i received byte strobe and data
//   txdBusy_i             transmitter busy
//   txdStart_o, txdData_o transmit strobe (one cycle) and byte
//   active_o              high whenever the FSM is not idle
//   bus                   device-bus initiator (uart_dbg_master_if.master)
`timescale 1ns/1ps
module uart_dbg_master #(
  parameter int unsigned RX_TIMEOUT  = 2500000,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rxdReady_i,
  input  logic [7:0]                rxdData_i,
  input  logic                      txdBusy_i,
  output logic                      txdStart_o,
  output logic [7:0]                txdData_o,
  output logic                      active_o,
  uart_dbg_master_if.master         bus
);

  localparam int unsigned RxCntW  = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned BusCntW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] RespOk   = 8'h4B;
  localparam logic [7:0] RespErr  = 8'h45;

  typedef enum logic [3:0] {
    StIdle, StRxAddr, StRxData, StRxBe, StReq, StAccess, StTxLoad, StTxWait, StTxGap
  } state_e;

  typedef enum logic [1:0] {RespData, RespAck, RespFail} resp_e;

  state_e               state_q;
  resp_e                resp_q;
  logic                 is_write_q;
  logic [2:0]           idx_q;
  logic [RxCntW-1:0]    rx_cnt_q;
  logic [BusCntW-1:0]   bus_cnt_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [3:0]           be_q;
  logic                 bus_req_q;
  logic                 dev_enable_q;
  logic                 dev_write_q;
  logic                 txd_start_q;
  logic [7:0]           txd_data_q;

  logic rx_expired;
  logic bus_expired;

  assign rx_expired  = (rx_cnt_q == RxCntW'(RX_TIMEOUT - 1));
  assign bus_expired = (bus_cnt_q == BusCntW'(BUS_TIMEOUT - 1));

  assign active_o              = (state_q != StIdle);
  assign txdStart_o            = txd_start_q;
  assign txdData_o             = txd_data_q;
  assign bus.busReq_o          = bus_req_q;
  assign bus.devEnable_o       = dev_enable_q;
  assign bus.devWrite_o        = dev_write_q;
  assign bus.devPhysicalAddr_o = addr_q;
  assign bus.devDataSave_o     = wdata_q;
  assign bus.devByteSelect_o   = be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      resp_q       <= RespData;
      is_write_q   <= 1'b0;
      idx_q        <= '0;
      rx_cnt_q     <= '0;
      bus_cnt_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      be_q         <= '0;
      bus_req_q    <= 1'b0;
      dev_enable_q <= 1'b0;
      dev_write_q  <= 1'b0;
      txd_start_q  <= 1'b0;
      txd_data_q   <= '0;
    end else begin
      // Strobe: only TX_WAIT raises it, so it can never last two cycles.
      txd_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rxdReady_i && (rxdData_i == CmdRead || rxdData_i == CmdWrite)) begin
            is_write_q <= (rxdData_i == CmdWrite);
            idx_q      <= '0;
            rx_cnt_q   <= '0;
            state_q    <= StRxAddr;
          end
        end
        StRxAddr, StRxData: begin
          if (rxdReady_i) begin
            rx_cnt_q <= '0;
            if (state_q == StRxAddr) addr_q[{idx_q[1:0], 3'b000} +: 8] <= rxdData_i;
            else                     wdata_q[{idx_q[1:0], 3'b000} +: 8] <= rxdData_i;
            if (idx_q == 3'd3) begin
              idx_q <= '0;
              if (state_q == StRxData) begin
                state_q <= StRxBe;
              end else if (is_write_q) begin
                state_q <= StRxData;
              end else begin
                be_q      <= 4'hf;
                bus_req_q <= 1'b1;
                state_q   <= StReq;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (rx_expired) begin
            state_q <= StIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        StRxBe: begin
          if (rxdReady_i) begin
            rx_cnt_q  <= '0;
            be_q      <= rxdData_i[3:0];
            bus_req_q <= 1'b1;
            state_q   <= StReq;
          end else if (rx_expired) begin
            state_q <= StIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        StReq: begin
          if (bus.busGnt_i) begin
            dev_enable_q <= 1'b1;
            dev_write_q  <= is_write_q;
            bus_cnt_q    <= '0;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          // Grant is not looked at here: once started, an access always runs to the end.
          if (!bus.devBusy_i || bus_expired) begin
            dev_enable_q <= 1'b0;
            dev_write_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            idx_q        <= '0;
            state_q      <= StTxLoad;
            if (bus.devBusy_i) begin
              resp_q <= RespFail;
            end else if (is_write_q) begin
              resp_q <= RespAck;
            end else begin
              resp_q  <= RespData;
              rdata_q <= bus.devDataLoad_i;
            end
          end else begin
            bus_cnt_q <= bus_cnt_q + 1'b1;
          end
        end
        StTxLoad: begin
          unique case (resp_q)
            RespData: txd_data_q <= rdata_q[{idx_q[1:0], 3'b000} +: 8];
            RespAck:  txd_data_q <= RespOk;
            default:  txd_data_q <= RespErr;
          endcase
          state_q <= StTxWait;
        end
        StTxWait: begin
          if (!txdBusy_i) begin
            txd_start_q <= 1'b1;
            state_q     <= StTxGap;
          end
        end
        StTxGap: begin
          // Gives the transmitter a cycle to raise busy after the strobe.
          if (resp_q == RespData && idx_q != 3'd3) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= StTxLoad;
          end else begin
            idx_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_master.sv
// Self-checking bench for uart_dbg_master: table of commands plus hand-written
// sequences for garbage bytes, RX timeout and reset during access / response.
`timescale 1ns/1ps
module tb_uart_dbg_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxdReady_i = 1'b0;
  logic [7:0] rxdData_i = 8'h00;
  logic       txd_busy = 1'b0;
  logic       txdStart_o;
  logic [7:0] txdData_o;
  logic       active_o;

  logic [31:0] load_cfg = 32'h0;
  int          busy_cfg = 0;
  int          gnt_cfg = 0;

  always #5 clk = ~clk;

  uart_dbg_master_if bus();
  assign bus.devDataLoad_i = load_cfg;

  uart_dbg_master #(
    .RX_TIMEOUT (100),
    .BUS_TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxdReady_i(rxdReady_i),
    .rxdData_i (rxdData_i),
    .txdBusy_i (txd_busy),
    .txdStart_o(txdStart_o),
    .txdData_o (txdData_o),
    .active_o  (active_o),
    .bus       (bus)
  );

  // ---------------- bus responder / arbiter model ----------------
  int          en_total = 0, unstable_total = 0, lowgnt_total = 0;
  int          req_pre_total = 0, req_post_total = 0;
  int          acc_idx = 0, req_cnt = 0;
  bit          seen_en = 1'b0;
  logic [31:0] cap_addr = 0, cap_data = 0;
  logic [3:0]  cap_be = 0;
  logic        cap_wr = 0;

  always @(negedge clk) begin
    if (bus.busReq_o && !bus.devEnable_o) begin
      if (seen_en) req_post_total++;
      else         req_pre_total++;
    end
    if (bus.devEnable_o) begin
      if (!seen_en) begin
        cap_addr = bus.devPhysicalAddr_o;
        cap_data = bus.devDataSave_o;
        cap_be   = bus.devByteSelect_o;
        cap_wr   = bus.devWrite_o;
      end else if ({bus.devPhysicalAddr_o, bus.devDataSave_o, bus.devByteSelect_o,
                    bus.devWrite_o} !== {cap_addr, cap_data, cap_be, cap_wr}) begin
        unstable_total++;
      end
      seen_en = 1'b1;
      en_total++;
      bus.devBusy_i = (acc_idx < busy_cfg);
      acc_idx++;
      bus.busGnt_i = 1'b0;  // grant drops mid-access; access must still finish
      req_cnt = 0;
    end else begin
      acc_idx = 0;
      bus.devBusy_i = 1'b0;
      if (bus.busReq_o) begin
        req_cnt++;
        bus.busGnt_i = (req_cnt > gnt_cfg);
        if (!bus.busGnt_i) lowgnt_total++;
      end else begin
        req_cnt = 0;
        bus.busGnt_i = 1'b0;
      end
    end
    if (!active_o) seen_en = 1'b0;
  end

  // ---------------- UART transmitter model ----------------
  logic [7:0] tx_log [64];
  int         tx_n = 0, busy_left = 0, consec_err = 0, start_busy_err = 0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (txdStart_o) begin
      if (prev_start) consec_err++;
      if (txd_busy) start_busy_err++;
      if (tx_n < 64) tx_log[tx_n] = txdData_o;
      tx_n++;
      txd_busy = 1'b1;
      busy_left = 4;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) txd_busy = 1'b0;
    end
    prev_start = txdStart_o;
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  be_byte;
    int          busy;
    int          gnt;
    logic [31:0] load;
    int          exp_en;
    logic [3:0]  exp_be;
    int          n_tx;
    logic [31:0] exp_tx;  // response bytes, first byte in [7:0]
  } vec_t;

  vec_t vecs [6];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxdReady_i = 1'b1;
    rxdData_i  = b;
    @(negedge clk);
    rxdReady_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input vec_t v);
    send_byte(v.wr ? 8'h57 : 8'h52);
    for (int k = 0; k < 4; k++) send_byte(v.addr[8*k +: 8]);
    if (v.wr) begin
      for (int k = 0; k < 4; k++) send_byte(v.wdata[8*k +: 8]);
      send_byte(v.be_byte);
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      #1;
      if (tx_n >= target && !active_o) ok = 1'b1;
      n++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          en0, low0, pre0, post0, tx0;
    bit          ok;
    logic [31:0] act_tx;
    busy_cfg = v.busy;
    gnt_cfg  = v.gnt;
    load_cfg = v.load;
    en0 = en_total; low0 = lowgnt_total; pre0 = req_pre_total;
    post0 = req_post_total; tx0 = tx_n;
    send_cmd(v);
    wait_done(tx0 + v.n_tx, 500, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_en_cycles"}, en_total - en0, v.exp_en);
    check({tag, "_addr"}, cap_addr, v.addr);
    check({tag, "_write"}, 32'(cap_wr), 32'(v.wr));
    if (v.wr) check({tag, "_wdata"}, cap_data, v.wdata);
    check({tag, "_be"}, 32'(cap_be), 32'(v.exp_be));
    check({tag, "_gnt_wait"}, lowgnt_total - low0, v.gnt);
    check({tag, "_req_pre"}, req_pre_total - pre0, v.gnt + 1);
    check({tag, "_req_post"}, req_post_total - post0, 0);
    check({tag, "_tx_count"}, tx_n - tx0, v.n_tx);
    act_tx = 32'h0;
    for (int k = 0; k < 4 && k < tx_n - tx0; k++) act_tx[8*k +: 8] = tx_log[(tx0 + k) % 64];
    check({tag, "_tx_bytes"}, act_tx, v.exp_tx);
  endtask

  initial begin
    int  en0, pre0, tx0, n;
    bit  ok;

    vecs[0] = '{wr: 1'b1, addr: 32'h8010_0000, wdata: 32'hDEAD_BEEF, be_byte: 8'h0F, busy: 0,
                gnt: 0, load: 32'h0, exp_en: 1, exp_be: 4'hf, n_tx: 1, exp_tx: 32'h4B};
    vecs[1] = '{wr: 1'b0, addr: 32'h8000_0004, wdata: 32'h0, be_byte: 8'h00, busy: 3,
                gnt: 0, load: 32'h1234_5678, exp_en: 4, exp_be: 4'hf, n_tx: 4,
                exp_tx: 32'h1234_5678};
    vecs[2] = '{wr: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, be_byte: 8'h00, busy: 0,
                gnt: 20, load: 32'hA5A5_0F0F, exp_en: 1, exp_be: 4'hf, n_tx: 4,
                exp_tx: 32'hA5A5_0F0F};
    vecs[3] = '{wr: 1'b1, addr: 32'h1234_5678, wdata: 32'h0000_0001, be_byte: 8'hF3, busy: 1,
                gnt: 0, load: 32'h0, exp_en: 2, exp_be: 4'h3, n_tx: 1, exp_tx: 32'h4B};
    vecs[4] = '{wr: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h0BAD_F00D, be_byte: 8'h0C, busy: 2,
                gnt: 5, load: 32'h0, exp_en: 3, exp_be: 4'hC, n_tx: 1, exp_tx: 32'h4B};
    vecs[5] = '{wr: 1'b0, addr: 32'h0000_ABCD, wdata: 32'h0, be_byte: 8'h00, busy: 1000,
                gnt: 0, load: 32'h1111_1111, exp_en: 16, exp_be: 4'hf, n_tx: 1,
                exp_tx: 32'h45};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_active", 32'(active_o), 32'd0);
    check("rst_txd", {23'd0, txdStart_o, txdData_o}, 32'd0);
    check("rst_bus_ctl", {28'd0, bus.busReq_o, bus.devEnable_o, bus.devWrite_o, 1'b0}, 32'd0);
    check("rst_addr", bus.devPhysicalAddr_o, 32'd0);
    check("rst_data", bus.devDataSave_o, 32'd0);
    check("rst_be", 32'(bus.devByteSelect_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-command bytes in idle are dropped
    en0 = en_total;
    send_byte(8'h00);
    #1 check("garbage_00", 32'(active_o), 32'd0);
    send_byte(8'h41);
    #1 check("garbage_41", 32'(active_o), 32'd0);
    send_byte(8'hFF);
    #1 check("garbage_ff", 32'(active_o), 32'd0);
    check("garbage_no_bus", en_total - en0, 0);

    // Table-driven commands
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // RX timeout: partial read dropped, following write executes
    en0 = en_total; pre0 = req_pre_total;
    send_byte(8'h52);
    send_byte(8'h00);
    #1 check("rxto_started", 32'(active_o), 32'd1);
    repeat (150) @(negedge clk);
    #1 check("rxto_idle", 32'(active_o), 32'd0);
    check("rxto_no_req", req_pre_total - pre0, 0);
    check("rxto_no_en", en_total - en0, 0);
    run_vec("rxto_wr", vecs[0]);

    // Reset during ACCESS
    busy_cfg = 1000; gnt_cfg = 0;
    send_byte(8'h52);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    ok = 1'b0; n = 0;
    while (!ok && n < 100) begin
      @(negedge clk); #1;
      if (bus.devEnable_o) ok = 1'b1;
      n++;
    end
    check("racc_reached", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("racc_en", 32'(bus.devEnable_o), 32'd0);
    check("racc_req", 32'(bus.busReq_o), 32'd0);
    check("racc_addr", bus.devPhysicalAddr_o, 32'd0);
    check("racc_active", 32'(active_o), 32'd0);
    en0 = en_total; tx0 = tx_n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("racc_no_en_after", en_total - en0, 0);
    check("racc_no_tx_after", tx_n - tx0, 0);

    // Reset while the second read-response byte is pending
    busy_cfg = 0; load_cfg = 32'hCAFE_F00D;
    tx0 = tx_n;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk); #1;
      if (tx_n >= tx0 + 1) ok = 1'b1;
      n++;
    end
    check("rtx_first_byte", 32'(ok), 32'd1);
    check("rtx_first_val", 32'(tx_log[tx0 % 64]), 32'h0D);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rtx_start", 32'(txdStart_o), 32'd0);
    check("rtx_data", 32'(txdData_o), 32'd0);
    check("rtx_active", 32'(active_o), 32'd0);
    check("rtx_dsave", bus.devDataSave_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("rtx_no_more_tx", tx_n - tx0, 1);
    check("rtx_idle", 32'(active_o), 32'd0);

    // Global protocol checks
    check("addr_stable", unstable_total, 0);
    check("start_consec", consec_err, 0);
    check("start_while_busy", start_busy_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
